fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_INIT, default 32'h00000000, PC value loaded on reset.
REQ-002 Port: CLK  in  1  single system clock, all state updates on rising edge.
REQ-003 Port: nRST  in  1  reset, asynchronous and active-low.
REQ-004 Port: imemREN  out  1  instruction memory read request.
REQ-005 Port: imemaddr  out  32  instruction fetch address (word aligned).
REQ-006 Port: ihit  in  1  memory returns imemload valid this cycle for imemaddr.
REQ-007 Port: imemload  in  32  fetched instruction word.
REQ-008 Port: stall  in  1  downstream decode stage (immediate generator side) cannot accept output this cycle.
REQ-009 Port: redirect  in  1  branch/jump taken; restart fetch at redirect_pc.
REQ-010 Port: redirect_pc  in  32  redirect target.
REQ-011 Port: halt  in  1  halt instruction retired; stop fetching.
REQ-012 Port: out_valid  out  1  out_inst/out_pc/out_npc hold a valid fetched instruction.
REQ-013 Port: out_inst  out  32  fetched instruction, consumed directly by the immediate generator and decoder.
REQ-014 Port: out_pc  out  32  address of out_inst.
REQ-015 Port: out_npc  out  32  out_pc + 4.
REQ-016 Port: fetch_cnt  out  32  count of instructions delivered.
REQ-017 Port: halted  out  1  block is in HALTED state.

Function
REQ-018 Two states: RUN, HALTED; reset enters RUN.
REQ-019 Internal pc register; imemaddr SHALL equal pc combinationally.
REQ-020 In RUN, imemREN = ~out_valid | ~stall; in HALTED, imemREN = 0.
REQ-021 Fetch accept: RUN & imemREN & ihit & ~redirect -> next cycle out_valid=1, out_inst=imemload, out_pc=pc, out_npc=pc+4, pc=pc+4, fetch_cnt+1.
REQ-022 out_valid & stall & ~redirect -> out_inst/out_pc/out_npc/out_valid held unchanged; pc unchanged.
REQ-023 out_valid & ~stall & no accept in same cycle -> out_valid cleared next cycle.
REQ-024 Accept and downstream consume in same cycle -> output register replaced by new instruction, out_valid stays 1 (no bubble).
REQ-025 ihit while imemREN=0 SHALL be ignored.
REQ-026 redirect in RUN (highest priority over accept and stall): pc <= {redirect_pc[31:2],2'b00}; out_valid <= 0; any ihit that cycle discarded; fetch_cnt unchanged.
REQ-027 halt in RUN (priority over redirect): state <= HALTED, out_valid <= 0, pc held; ihit that cycle discarded.
REQ-028 HALTED is terminal: redirect, ihit, stall, halt ignored; exit only via nRST.
REQ-029 pc+4 arithmetic is 32-bit modulo: pc 32'hFFFFFFFC accept -> pc 32'h00000000, out_npc 32'h00000000.
REQ-030 fetch_cnt wraps 32'hFFFFFFFF -> 0.
REQ-031 halted = (state == HALTED).

Reset
REQ-032 nRST low asynchronously forces: state RUN, pc=PC_INIT, out_valid=0, out_inst=0, out_pc=0, out_npc=0, fetch_cnt=0.
REQ-033 Reset asserted mid-fetch or in HALTED discards all in-flight state; first request after release addresses PC_INIT.
REQ-034 imemREN SHALL be 1 in the first cycle after nRST deasserts (out_valid=0, RUN).

Verification
REQ-035 Reset, ihit=1 every cycle, stall=0, imemload=0x00A00093,0x00100113,... -> out_pc 0,4,8 on consecutive cycles, out_valid continuous, fetch_cnt=3 after three accepts.
REQ-036 Accept at pc=0x10, then stall=1 for 3 cycles with ihit=1 -> out_pc stays 0x10, imemREN=0, pc stays 0x14; stall drop -> next out_pc=0x14.
REQ-037 redirect=1, redirect_pc=0x00000203 with ihit=1 same cycle -> next cycle out_valid=0, imemaddr=0x200, fetch_cnt unchanged.
REQ-038 halt=1 and redirect=1 same cycle -> halted=1, imemREN=0, out_valid=0; later redirect/ihit cause no change.
REQ-039 PC_INIT=0xFFFFFFFC, one accept -> out_pc=0xFFFFFFFC, out_npc=0, imemaddr=0.
REQ-040 nRST pulsed low mid-stall with out_valid=1 -> outputs clear immediately without a clock edge; imemaddr=PC_INIT after release.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- single-entry instruction fetch stage.
//
// Keeps the fetch pc, issues word-aligned reads to instruction memory and holds
// one fetched instruction in an output register for the decode stage. Redirects
// restart fetch at a new target. A retired halt freezes the unit until reset.
//
// Parameters
//   PC_INIT      pc value loaded on reset
// Ports
//   CLK          system clock, rising-edge active
//   nRST         asynchronous active-low reset
//   imemREN      instruction memory read request
//   imemaddr     fetch address (always equals the pc register)
//   ihit         imemload is valid this cycle for imemaddr
//   imemload     fetched instruction word
//   stall        decode stage cannot take the output this cycle
//   redirect     branch/jump taken, restart at redirect_pc
//   redirect_pc  redirect target (low two bits dropped)
//   halt         halt retired, stop fetching
//   out_valid    out_inst/out_pc/out_npc hold a valid instruction
//   out_inst     fetched instruction
//   out_pc       address of out_inst
//   out_npc      out_pc + 4
//   fetch_cnt    number of instructions delivered (wraps)
//   halted       unit is in the HALTED state
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h00000000
) (
   input  logic        CLK,
   input  logic        nRST,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        out_valid,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   output logic [31:0] out_npc,
   output logic [31:0] fetch_cnt,
   output logic        halted
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t      state_r, state_n_s;
   logic [31:0] pc_r, pc_n_s;
   logic        out_valid_r, out_valid_n_s;
   logic [31:0] out_inst_r, out_inst_n_s;
   logic [31:0] out_pc_r, out_pc_n_s;
   logic [31:0] out_npc_r, out_npc_n_s;
   logic [31:0] fetch_cnt_r, fetch_cnt_n_s;
   logic        ren_s;
   logic        accept_s;
   logic [31:0] pc_plus4_s;

   // A new word may be requested whenever the output register is empty or
   // is being drained this cycle; this is what makes back-to-back delivery
   // bubble-free.
   assign ren_s      = (state_r == RUN) & (~out_valid_r | ~stall);
   assign accept_s   = ren_s & ihit;
   assign pc_plus4_s = pc_r + 32'd4;

   // Next-state and next-output-register selection; halt beats redirect,
   // redirect beats accept and stall.
   always_comb begin
      state_n_s     = state_r;
      pc_n_s        = pc_r;
      out_valid_n_s = out_valid_r;
      out_inst_n_s  = out_inst_r;
      out_pc_n_s    = out_pc_r;
      out_npc_n_s   = out_npc_r;
      fetch_cnt_n_s = fetch_cnt_r;
      case (state_r)
         RUN: begin
            if (halt) begin
               state_n_s     = HALTED;
               out_valid_n_s = 1'b0;
            end else if (redirect) begin
               pc_n_s        = {redirect_pc[31:2], 2'b00};
               out_valid_n_s = 1'b0;
            end else if (accept_s) begin
               out_valid_n_s = 1'b1;
               out_inst_n_s  = imemload;
               out_pc_n_s    = pc_r;
               out_npc_n_s   = pc_plus4_s;
               pc_n_s        = pc_plus4_s;
               fetch_cnt_n_s = fetch_cnt_r + 32'd1;
            end else if (out_valid_r & ~stall) begin
               // Consumed with nothing new arriving.
               out_valid_n_s = 1'b0;
            end else begin
               // Stalled or idle: everything holds.
               out_valid_n_s = out_valid_r;
            end
         end
         HALTED: begin
            // Terminal until reset.
            state_n_s = HALTED;
         end
         default: begin
            state_n_s     = HALTED;
            out_valid_n_s = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r     <= RUN;
         pc_r        <= PC_INIT;
         out_valid_r <= 1'b0;
         out_inst_r  <= 32'h00000000;
         out_pc_r    <= 32'h00000000;
         out_npc_r   <= 32'h00000000;
         fetch_cnt_r <= 32'h00000000;
      end else begin
         state_r     <= state_n_s;
         pc_r        <= pc_n_s;
         out_valid_r <= out_valid_n_s;
         out_inst_r  <= out_inst_n_s;
         out_pc_r    <= out_pc_n_s;
         out_npc_r   <= out_npc_n_s;
         fetch_cnt_r <= fetch_cnt_n_s;
      end
   end

   assign imemREN   = ren_s;
   assign imemaddr  = pc_r;
   assign out_valid = out_valid_r;
   assign out_inst  = out_inst_r;
   assign out_pc    = out_pc_r;
   assign out_npc   = out_npc_r;
   assign fetch_cnt = fetch_cnt_r;
   assign halted    = (state_r == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit.
// A behavioural model (plain variables updated by the fetch rules) predicts
// every output; directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        ihit = 1'b0;
   logic [31:0] imemload = 32'h00000000;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h00000000;
   logic        halt = 1'b0;

   logic        imemREN, out_valid, halted;
   logic [31:0] imemaddr, out_inst, out_pc, out_npc, fetch_cnt;

   logic        hi_imemREN, hi_out_valid, hi_halted;
   logic [31:0] hi_imemaddr, hi_out_inst, hi_out_pc, hi_out_npc, hi_fetch_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [31:0] m_pc, m_inst, m_opc, m_npc, m_cnt;
   logic        m_valid, m_halted;

   always #5 CLK = ~CLK;

   fetch_unit u_dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .halt(halt), .out_valid(out_valid),
      .out_inst(out_inst), .out_pc(out_pc), .out_npc(out_npc),
      .fetch_cnt(fetch_cnt), .halted(halted)
   );

   fetch_unit #(.PC_INIT(32'hFFFFFFFC)) u_dut_hi (
      .CLK(CLK), .nRST(nRST), .imemREN(hi_imemREN), .imemaddr(hi_imemaddr),
      .ihit(ihit), .imemload(imemload), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .halt(halt), .out_valid(hi_out_valid),
      .out_inst(hi_out_inst), .out_pc(hi_out_pc), .out_npc(hi_out_npc),
      .fetch_cnt(hi_fetch_cnt), .halted(hi_halted)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic check_regs(input string pfx);
      check_val({pfx, " out_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
      check_val({pfx, " out_inst"}, out_inst, m_inst);
      check_val({pfx, " out_pc"}, out_pc, m_opc);
      check_val({pfx, " out_npc"}, out_npc, m_npc);
      check_val({pfx, " fetch_cnt"}, fetch_cnt, m_cnt);
      check_val({pfx, " halted"}, {31'd0, halted}, {31'd0, m_halted});
   endtask

   // Apply one cycle of inputs (called at a negedge); checks request outputs,
   // advances the model at the rising edge, then checks the registers.
   task automatic step(input logic i_hit, input logic i_stall, input logic i_red,
                       input logic [31:0] i_rpc, input logic i_halt, input logic [31:0] i_load);
      logic exp_ren;
      ihit = i_hit; stall = i_stall; redirect = i_red;
      redirect_pc = i_rpc; halt = i_halt; imemload = i_load;
      #1;
      exp_ren = !m_halted && (!m_valid || !i_stall);
      check_val("imemREN", {31'd0, imemREN}, {31'd0, exp_ren});
      check_val("imemaddr", imemaddr, m_pc);
      @(posedge CLK);
      if (!m_halted) begin
         if (i_halt) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
         end else if (i_red) begin
            m_pc    = i_rpc & 32'hFFFFFFFC;
            m_valid = 1'b0;
         end else if (exp_ren && i_hit) begin
            m_inst  = i_load;
            m_opc   = m_pc;
            m_npc   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
         end else if (!i_stall) begin
            m_valid = 1'b0;
         end
      end
      @(negedge CLK);
      check_regs("step");
   endtask

   // Asynchronous reset pulse placed between clock edges; returns at a negedge.
   task automatic do_reset();
      #2;
      nRST = 1'b0;
      ihit = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
      m_pc = 32'h00000000; m_inst = 32'h0; m_opc = 32'h0; m_npc = 32'h0;
      m_cnt = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
      #1;
      check_regs("reset");
      check_val("reset imemaddr", imemaddr, 32'h00000000);
      check_val("reset hi imemaddr", hi_imemaddr, 32'hFFFFFFFC);
      @(negedge CLK);
      nRST = 1'b1;
      #1;
      check_val("post-reset imemREN", {31'd0, imemREN}, 32'd1);
      @(negedge CLK);
   endtask

   initial begin
      @(negedge CLK);
      do_reset();

      // PC_INIT near the top of the address space wraps on the first accept.
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00A00093);
      check_val("hi out_pc", hi_out_pc, 32'hFFFFFFFC);
      check_val("hi out_npc", hi_out_npc, 32'h00000000);
      check_val("hi imemaddr", hi_imemaddr, 32'h00000000);
      check_val("hi out_inst", hi_out_inst, 32'h00A00093);
      check_val("hi out_valid", {31'd0, hi_out_valid}, 32'd1);
      check_val("hi fetch_cnt", hi_fetch_cnt, 32'd1);
      check_val("hi halted", {31'd0, hi_halted}, 32'd0);
      check_val("hi imemREN", {31'd0, hi_imemREN}, 32'd1);

      // Streaming fetch from 0.
      do_reset();
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00A00093);
      check_val("stream pc0", out_pc, 32'h00000000);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h00100113);
      check_val("stream pc4", out_pc, 32'h00000004);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h002081B3);
      check_val("stream pc8", out_pc, 32'h00000008);
      check_val("stream cnt3", fetch_cnt, 32'd3);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h11111111);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h22222222);
      check_val("accept at 0x10", out_pc, 32'h00000010);

      // Stall holds output and pc.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'hDEAD0000 + i);
         check_val("stall out_pc", out_pc, 32'h00000010);
         check_val("stall imemaddr", imemaddr, 32'h00000014);
         check_val("stall imemREN", {31'd0, imemREN}, 32'd0);
      end
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h33333333);
      check_val("unstall out_pc", out_pc, 32'h00000014);

      // Redirect with a simultaneous hit.
      step(1'b1, 1'b0, 1'b1, 32'h00000203, 1'b0, 32'h44444444);
      check_val("redirect valid", {31'd0, out_valid}, 32'd0);
      check_val("redirect addr", imemaddr, 32'h00000200);
      check_val("redirect cnt", fetch_cnt, 32'd6);

      // Halt beats redirect; HALTED ignores everything.
      step(1'b1, 1'b0, 1'b1, 32'h00000400, 1'b1, 32'h55555555);
      check_val("halt halted", {31'd0, halted}, 32'd1);
      for (int i = 0; i < 4; i++)
         step(1'b1, $urandom_range(0, 1) == 0, 1'b1, $urandom, $urandom_range(0, 1) == 0, $urandom);
      check_val("halt pc held", imemaddr, 32'h00000200);

      // Reset while stalled with a valid output.
      do_reset();
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h66666666);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h77777777);
      do_reset();
      check_val("mid-stall reset addr", imemaddr, 32'h00000000);

      // Randomized run.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 2 || (m_halted && $urandom_range(0, 9) == 0))
            do_reset();
         else
            step($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, $urandom,
                 $urandom_range(0, 63) == 0, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
